// File: rtl/estado_temp_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : temp_pkg
// Description : Shared types and default sizing for the multi-channel
//               temperature-state monitor (estado_temp_multi).
//               estado_t encodes the per-channel state exactly as it appears
//               on estado_actual.
// Revision    : 1.0 - initial release
// ============================================================================
package temp_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    BAJO   = 2'b01,
    ALTO   = 2'b10,
    ALERTA = 2'b11
  } estado_t;

  localparam int C_NCH_DEF       = 4;
  localparam int C_W_DEF         = 11;
  localparam int C_N_PERSIST_DEF = 5;

endpackage : temp_pkg
`default_nettype wire

// File: rtl/estado_temp_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : estado_temp_multi_if
// Description : Sample/configuration/result bundle of estado_temp_multi.
//               master : sample source and alarm consumer (drives samples,
//                        thresholds, acks; reads alarms/actuators).
//               slave  : the monitor itself.
// Ports       : muestra_valid, temp_in[NCH*W], umbral_bajo, umbral_alto,
//               histeresis[W-1], ack_alerta[NCH]  (master -> slave)
//               alerta[NCH], alerta_any, calefactor[NCH], ventilador[NCH],
//               estado_actual[2*NCH], config_err  (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface estado_temp_multi_if
  import temp_pkg::*;
#(
  parameter int NCH = C_NCH_DEF,
  parameter int W   = C_W_DEF
);

  logic                  muestra_valid;
  logic [NCH*W-1:0]      temp_in;
  logic signed [W-1:0]   umbral_bajo;
  logic signed [W-1:0]   umbral_alto;
  logic [W-2:0]          histeresis;
  logic [NCH-1:0]        ack_alerta;

  logic [NCH-1:0]        alerta;
  logic                  alerta_any;
  logic [NCH-1:0]        calefactor;
  logic [NCH-1:0]        ventilador;
  logic [2*NCH-1:0]      estado_actual;
  logic                  config_err;

  modport master (
    output muestra_valid, temp_in, umbral_bajo, umbral_alto, histeresis, ack_alerta,
    input  alerta, alerta_any, calefactor, ventilador, estado_actual, config_err
  );

  modport slave (
    input  muestra_valid, temp_in, umbral_bajo, umbral_alto, histeresis, ack_alerta,
    output alerta, alerta_any, calefactor, ventilador, estado_actual, config_err
  );

endinterface : estado_temp_multi_if
`default_nettype wire

// File: rtl/estado_temp_multi_canal.sv
`default_nettype none
// ============================================================================
// Module      : canal_temp
// Description : One temperature channel: NORMAL/BAJO/ALTO/ALERTA FSM with a
//               saturating persistence counter, heater/fan commands and the
//               optional sticky alert (macro ESTADO_TEMP_ALERT_LATCH_EN).
// Ports       : clk, arst_n         clock, async active-low reset
//               en                  sample strobe already gated by config_err
//               ack                 alert acknowledge (latch build only)
//               t                   signed sample
//               umbral_bajo/alto    signed thresholds
//               lim_lo/lim_hi       hysteresis limits, W+1 bits signed
//               alerta, calefactor, ventilador, estado
// Revision    : 1.0 - initial release
// ============================================================================
module canal_temp
  import temp_pkg::*;
#(
  parameter int W         = C_W_DEF,
  parameter int N_PERSIST = C_N_PERSIST_DEF
) (
  input  wire logic                clk,
  input  wire logic                arst_n,
  input  wire logic                en,
  input  wire logic                ack,
  input  wire logic signed [W-1:0] t,
  input  wire logic signed [W-1:0] umbral_bajo,
  input  wire logic signed [W-1:0] umbral_alto,
  input  wire logic signed [W:0]   lim_lo,
  input  wire logic signed [W:0]   lim_hi,
  output logic                     alerta,
  output logic                     calefactor,
  output logic                     ventilador,
  output logic [1:0]               estado
);

  localparam int             CW        = $clog2(N_PERSIST + 1);
  localparam logic [CW-1:0]  C_CNT_MAX = CW'(N_PERSIST);

  estado_t        r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic           r_cal, w_cal_nxt;
  logic           r_ven, w_ven_nxt;

  // All comparisons in W+1 bits so they line up with the limits.
  logic signed [W:0] w_t, w_bajo, w_alto;
  logic              w_lt_bajo, w_gt_alto, w_ge_lo, w_le_hi;

  assign w_t       = {t[W-1], t};
  assign w_bajo    = {umbral_bajo[W-1], umbral_bajo};
  assign w_alto    = {umbral_alto[W-1], umbral_alto};
  assign w_lt_bajo = (w_t < w_bajo);
  assign w_gt_alto = (w_t > w_alto);
  assign w_ge_lo   = (w_t >= lim_lo);
  assign w_le_hi   = (w_t <= lim_hi);
  assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= NORMAL;
      r_cnt   <= '0;
      r_cal   <= 1'b0;
      r_ven   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cal   <= w_cal_nxt;
      r_ven   <= w_ven_nxt;
    end
  end

  // Next-state logic; everything holds unless a valid, well-configured sample arrives.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cal_nxt   = r_cal;
    w_ven_nxt   = r_ven;
    if (en) begin
      case (r_state)
        NORMAL: begin
          w_cal_nxt = 1'b0;
          w_ven_nxt = 1'b0;
          if (w_lt_bajo) begin
            w_state_nxt = BAJO;
            w_cnt_nxt   = CW'(1);
          end else if (w_gt_alto) begin
            w_state_nxt = ALTO;
            w_cnt_nxt   = CW'(1);
          end else begin
            w_cnt_nxt   = '0;
          end
        end
        BAJO: begin
          if (w_gt_alto) begin
            w_state_nxt = ALTO;
            w_cnt_nxt   = CW'(1);
          end else if (w_lt_bajo) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == C_CNT_MAX) begin
              w_state_nxt = ALERTA;
              w_cal_nxt   = 1'b1;
              w_ven_nxt   = 1'b0;
            end
          end else if (w_ge_lo) begin
            w_state_nxt = NORMAL;
            w_cnt_nxt   = '0;
          end
          // umbral_bajo <= t < lim_lo: inside the band, hold count.
        end
        ALTO: begin
          if (w_lt_bajo) begin
            w_state_nxt = BAJO;
            w_cnt_nxt   = CW'(1);
          end else if (w_gt_alto) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == C_CNT_MAX) begin
              w_state_nxt = ALERTA;
              w_ven_nxt   = 1'b1;
              w_cal_nxt   = 1'b0;
            end
          end else if (w_le_hi) begin
            w_state_nxt = NORMAL;
            w_cnt_nxt   = '0;
          end
        end
        ALERTA: begin
          if (w_lt_bajo) begin
            w_cal_nxt = 1'b1;
            w_ven_nxt = 1'b0;
          end else if (w_gt_alto) begin
            w_ven_nxt = 1'b1;
            w_cal_nxt = 1'b0;
          end else if (w_ge_lo && w_le_hi) begin
            w_state_nxt = NORMAL;
            w_cnt_nxt   = '0;
            w_cal_nxt   = 1'b0;
            w_ven_nxt   = 1'b0;
          end
        end
        default: begin
          w_state_nxt = NORMAL;
          w_cnt_nxt   = '0;
          w_cal_nxt   = 1'b0;
          w_ven_nxt   = 1'b0;
        end
      endcase
    end
  end

`ifdef ESTADO_TEMP_ALERT_LATCH_EN
  logic r_alerta_lat;

  // Set wins over ack; ack only acts once the channel has left ALERTA.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_alerta_lat <= 1'b0;
    end else if (w_state_nxt == ALERTA) begin
      r_alerta_lat <= 1'b1;
    end else if (ack && (r_state != ALERTA)) begin
      r_alerta_lat <= 1'b0;
    end
  end
`else
  logic w_unused_ack;
  assign w_unused_ack = ack;
`endif

  // Output logic
  always_comb begin
    estado     = r_state;
    calefactor = r_cal;
    ventilador = r_ven;
`ifdef ESTADO_TEMP_ALERT_LATCH_EN
    alerta     = r_alerta_lat;
`else
    alerta     = (r_state == ALERTA);
`endif
  end

endmodule : canal_temp
`default_nettype wire

// File: rtl/estado_temp_multi.sv
`default_nettype none
// ============================================================================
// Module      : estado_temp_multi
// Description : NCH-channel temperature-state monitor. Computes hysteresis
//               limits and config_err once, gates the sample strobe with it,
//               and runs one canal_temp per channel.
//               Optional macro: ESTADO_TEMP_ALERT_LATCH_EN (sticky alerts
//               cleared by ack_alerta).
// Ports       : clk     system clock
//               arst_n  asynchronous active-low reset
//               bus     estado_temp_multi_if.slave (samples, thresholds,
//                       acks in; alerts, actuators, states, config_err out)
// Revision    : 1.0 - initial release
// ============================================================================
module estado_temp_multi
  import temp_pkg::*;
#(
  parameter int NCH       = C_NCH_DEF,
  parameter int W         = C_W_DEF,
  parameter int N_PERSIST = C_N_PERSIST_DEF
) (
  input wire logic          clk,
  input wire logic          arst_n,
  estado_temp_multi_if.slave bus
);

  logic signed [W:0] w_bajo_ext, w_alto_ext, w_hist_ext;
  logic signed [W:0] w_lim_lo, w_lim_hi;
  logic              w_config_err, w_en;

  // One extra bit keeps bajo+hist and alto-hist free of overflow.
  assign w_bajo_ext   = {bus.umbral_bajo[W-1], bus.umbral_bajo};
  assign w_alto_ext   = {bus.umbral_alto[W-1], bus.umbral_alto};
  assign w_hist_ext   = {2'b00, bus.histeresis};
  assign w_lim_lo     = w_bajo_ext + w_hist_ext;
  assign w_lim_hi     = w_alto_ext - w_hist_ext;
  assign w_config_err = (w_lim_lo > w_lim_hi);
  assign w_en         = bus.muestra_valid && !w_config_err;

  logic [NCH-1:0]   w_alerta, w_cal, w_ven;
  logic [2*NCH-1:0] w_estado;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    canal_temp #(
      .W         (W),
      .N_PERSIST (N_PERSIST)
    ) u_canal (
      .clk         (clk),
      .arst_n      (arst_n),
      .en          (w_en),
      .ack         (bus.ack_alerta[i]),
      .t           (bus.temp_in[i*W +: W]),
      .umbral_bajo (bus.umbral_bajo),
      .umbral_alto (bus.umbral_alto),
      .lim_lo      (w_lim_lo),
      .lim_hi      (w_lim_hi),
      .alerta      (w_alerta[i]),
      .calefactor  (w_cal[i]),
      .ventilador  (w_ven[i]),
      .estado      (w_estado[2*i +: 2])
    );
  end

  assign bus.alerta        = w_alerta;
  assign bus.alerta_any    = |w_alerta;
  assign bus.calefactor    = w_cal;
  assign bus.ventilador    = w_ven;
  assign bus.estado_actual = w_estado;
  assign bus.config_err    = w_config_err;

endmodule : estado_temp_multi
`default_nettype wire
